// File: rtl/noc_pkg.sv
// Shared types and helpers for the mesh-router input stage.
// Holds the flit type encoding, output port indices and the XY route function.
package noc_pkg;

    typedef enum logic [1:0] {
        FT_HEAD   = 2'b00,
        FT_BODY   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_t;

    localparam int NUM_PORTS = 5;
    localparam int P_LOCAL   = 0;
    localparam int P_EAST    = 1;
    localparam int P_WEST    = 2;
    localparam int P_NORTH   = 3;
    localparam int P_SOUTH   = 4;

    function automatic logic is_head_type(input flit_type_t t);
        return (t == FT_HEAD) || (t == FT_SINGLE);
    endfunction

    function automatic logic is_tail_type(input flit_type_t t);
        return (t == FT_TAIL) || (t == FT_SINGLE);
    endfunction

    // The coordinate fields sit in the low 2*cw bits of a head flit: X above Y.
    function automatic logic [31:0] head_dest_x(input logic [31:0] lo, input int cw);
        return (lo >> cw) & ((32'd1 << cw) - 32'd1);
    endfunction

    function automatic logic [31:0] head_dest_y(input logic [31:0] lo, input int cw);
        return lo & ((32'd1 << cw) - 32'd1);
    endfunction

    // Dimension-ordered routing: resolve X fully before Y.
    function automatic logic [NUM_PORTS-1:0] xy_route(input logic [31:0] dx, input logic [31:0] dy,
                                                       input logic [31:0] mx, input logic [31:0] my);
        logic [NUM_PORTS-1:0] p;
        p = '0;
        if (dx > mx)      p[P_EAST]  = 1'b1;
        else if (dx < mx) p[P_WEST]  = 1'b1;
        else if (dy > my) p[P_NORTH] = 1'b1;
        else if (dy < my) p[P_SOUTH] = 1'b1;
        else              p[P_LOCAL] = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Per-VC synchronous flit FIFO with a combinational head-of-queue view.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module noc_flit_fifo #(
    parameter int DATA_W = 35,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty,
    output logic [CW-1:0]     o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/noc_vc_input_unit.sv
// Router input port: per-VC buffering, XY route lookup, packet lock and credit return.
// Each VC runs an IDLE/ACTIVE FSM; the route is latched from the head flit and held for the packet.
module noc_vc_input_unit
    import noc_pkg::*;
#(
    parameter int DATA_W  = 35,
    parameter int NUM_VC  = 2,
    parameter int DEPTH   = 4,
    parameter int COORD_W = 2,
    localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                        clk,
    input  logic                        RST,
    input  logic [COORD_W-1:0]          MY_XPOS,
    input  logic [COORD_W-1:0]          MY_YPOS,
    input  logic [DATA_W-1:0]           IDATA,
    input  logic                        IVALID,
    input  logic [VC_W-1:0]             IVCH,
    output logic [NUM_VC-1:0]           OACK,
    output logic [NUM_VC-1:0]           OLCK,
    output logic [NUM_VC-1:0]           REQ_VALID,
    output logic [NUM_VC*NUM_PORTS-1:0] REQ_PORT,
    output logic [NUM_VC*DATA_W-1:0]    FLIT_OUT,
    input  logic [NUM_VC-1:0]           GRANT,
    output logic                        ERR
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              w_bad_vc;
    logic [NUM_VC-1:0] w_err_vc;
    logic              r_err;

    // Out-of-range VC ids only exist when NUM_VC is not a power of two.
    generate
        if (NUM_VC < (1 << VC_W)) begin : g_vc_range
            assign w_bad_vc = IVALID && (32'(IVCH) >= NUM_VC);
        end else begin : g_vc_full_range
            assign w_bad_vc = 1'b0;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
            logic                 w_push;
            logic                 w_pop;
            logic                 w_full;
            logic                 w_empty;
            logic [CNT_W-1:0]     w_count;
            logic [DATA_W-1:0]    w_front;
            flit_type_t           w_ftype;
            vc_state_t            r_state;
            vc_state_t            w_state_next;
            logic                 w_req_valid;
            logic                 w_gpop;
            logic                 w_discard;
            logic                 w_load_route;
            logic [NUM_PORTS-1:0] w_route_calc;
            logic [NUM_PORTS-1:0] r_route;
            logic                 r_oack;
            logic                 r_olck;

            assign w_push = IVALID && !w_bad_vc && (IVCH == VC_W'(gi));
            assign w_pop  = w_gpop || w_discard;

            noc_flit_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .RST     (RST),
                .i_push  (w_push),
                .i_din   (IDATA),
                .i_pop   (w_pop),
                .o_dout  (w_front),
                .o_full  (w_full),
                .o_empty (w_empty),
                .o_count (w_count)
            );

            assign w_ftype      = flit_type_t'(w_front[DATA_W-1 -: 2]);
            assign w_route_calc = xy_route(head_dest_x(32'(w_front[2*COORD_W-1:0]), COORD_W),
                                           head_dest_y(32'(w_front[2*COORD_W-1:0]), COORD_W),
                                           32'(MY_XPOS), 32'(MY_YPOS));

            always_ff @(posedge clk or posedge RST) begin
                if (RST) r_state <= VC_IDLE;
                else     r_state <= w_state_next;
            end

            always_comb begin
                w_state_next = r_state;
                case (r_state)
                    VC_IDLE:   if (!w_empty && is_head_type(w_ftype)) w_state_next = VC_ACTIVE;
                    VC_ACTIVE: if (w_gpop && is_tail_type(w_ftype))   w_state_next = VC_IDLE;
                    default:   w_state_next = VC_IDLE;
                endcase
            end

            always_comb begin
                w_req_valid  = 1'b0;
                w_gpop       = 1'b0;
                w_discard    = 1'b0;
                w_load_route = 1'b0;
                case (r_state)
                    VC_IDLE: begin
                        w_load_route = !w_empty && is_head_type(w_ftype);
                        w_discard    = !w_empty && !is_head_type(w_ftype);
                    end
                    VC_ACTIVE: begin
                        w_req_valid = !w_empty;
                        w_gpop      = GRANT[gi] && !w_empty;
                    end
                    default: ;
                endcase
            end

            // A push to a full FIFO only counts as an error if nothing drains this cycle.
            assign w_err_vc[gi] = w_discard
                                || (GRANT[gi] && !w_req_valid)
                                || (w_push && w_full && !w_pop);

            always_ff @(posedge clk or posedge RST) begin
                if (RST) begin
                    r_route <= '0;
                    r_oack  <= 1'b0;
                    r_olck  <= 1'b0;
                end else begin
                    if (w_load_route) r_route <= w_route_calc;
                    r_oack <= w_pop;
                    if (w_gpop && w_ftype == FT_HEAD)      r_olck <= 1'b1;
                    else if (w_gpop && w_ftype == FT_TAIL) r_olck <= 1'b0;
                end
            end

            assign OACK[gi]                              = r_oack;
            assign OLCK[gi]                              = r_olck;
            assign REQ_VALID[gi]                         = w_req_valid;
            assign REQ_PORT[gi*NUM_PORTS +: NUM_PORTS]   = r_route;
            assign FLIT_OUT[gi*DATA_W +: DATA_W]         = (w_count != '0) ? w_front : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge RST) begin
        if (RST) r_err <= 1'b0;
        else     r_err <= r_err || w_bad_vc || (|w_err_vc);
    end

    assign ERR = r_err;

endmodule

// File: tb/tb_noc_vc_input_unit.sv
// Directed bench for noc_vc_input_unit with MY=(1,1), NUM_VC=2, DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_noc_vc_input_unit;

    localparam int DW = 35;

    logic          clk;
    logic          RST;
    logic [1:0]    MY_XPOS;
    logic [1:0]    MY_YPOS;
    logic [DW-1:0] IDATA;
    logic          IVALID;
    logic [0:0]    IVCH;
    logic [1:0]    OACK;
    logic [1:0]    OLCK;
    logic [1:0]    REQ_VALID;
    logic [9:0]    REQ_PORT;
    logic [69:0]   FLIT_OUT;
    logic [1:0]    GRANT;
    logic          ERR;

    int n_checks = 0;
    int n_pass   = 0;

    noc_vc_input_unit #(
        .DATA_W  (35),
        .NUM_VC  (2),
        .DEPTH   (4),
        .COORD_W (2)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .MY_XPOS   (MY_XPOS),
        .MY_YPOS   (MY_YPOS),
        .IDATA     (IDATA),
        .IVALID    (IVALID),
        .IVCH      (IVCH),
        .OACK      (OACK),
        .OLCK      (OLCK),
        .REQ_VALID (REQ_VALID),
        .REQ_PORT  (REQ_PORT),
        .FLIT_OUT  (FLIT_OUT),
        .GRANT     (GRANT),
        .ERR       (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] mkf(input logic [1:0] t, input logic [28:0] pl,
                                          input logic [1:0] dx, input logic [1:0] dy);
        return {t, pl, dx, dy};
    endfunction

    task automatic push(input logic vc, input logic [DW-1:0] f);
        IVALID = 1'b1; IVCH = vc; IDATA = f;
        cyc();
        IVALID = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc(); cyc();
        RST = 1'b0;
    endtask

    logic [DW-1:0] f;
    logic [DW-1:0] pk [4];
    logic [DW-1:0] a0h, a0t, a1h, a1t;

    initial begin
        RST = 1'b1; MY_XPOS = 2'd1; MY_YPOS = 2'd1;
        IDATA = '0; IVALID = 1'b0; IVCH = 1'b0; GRANT = 2'b00;
        cyc(); cyc();
        chk("rst_oack", 64'(OACK), 64'd0);
        chk("rst_olck", 64'(OLCK), 64'd0);
        chk("rst_reqv", 64'(REQ_VALID), 64'd0);
        chk("rst_port", 64'(REQ_PORT), 64'd0);
        chk("rst_flit", 64'(FLIT_OUT), 64'd0);
        chk("rst_err",  64'(ERR), 64'd0);
        RST = 1'b0;
        cyc();

        // single flit east
        f = mkf(2'b11, 29'h123, 2'd3, 2'd1);
        push(1'b0, f);
        chk("sgl_reqv_t1", 64'(REQ_VALID), 64'd0);
        cyc();
        chk("sgl_reqv_t2", 64'(REQ_VALID), 64'b01);
        chk("sgl_port",    64'(REQ_PORT[4:0]), 64'b00010);
        chk("sgl_flit",    64'(FLIT_OUT[34:0]), 64'(f));
        GRANT = 2'b01; cyc(); GRANT = 2'b00;
        chk("sgl_oack",    64'(OACK), 64'b01);
        chk("sgl_reqv_po", 64'(REQ_VALID), 64'd0);
        chk("sgl_olck",    64'(OLCK), 64'd0);
        cyc();
        chk("sgl_oack_off", 64'(OACK), 64'd0);

        // 4-flit packet south on VC1
        pk[0] = mkf(2'b00, 29'h10, 2'd1, 2'd0);
        pk[1] = mkf(2'b01, 29'h11, 2'd0, 2'd0);
        pk[2] = mkf(2'b01, 29'h12, 2'd3, 2'd3);
        pk[3] = mkf(2'b10, 29'h13, 2'd2, 2'd2);
        for (int k = 0; k < 4; k++) push(1'b1, pk[k]);
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pkt_reqv%0d", k), 64'(REQ_VALID), 64'b10);
            chk($sformatf("pkt_port%0d", k), 64'(REQ_PORT[9:5]), 64'b10000);
            chk($sformatf("pkt_flit%0d", k), 64'(FLIT_OUT[69:35]), 64'(pk[k]));
            GRANT = 2'b10; cyc(); GRANT = 2'b00;
            chk($sformatf("pkt_oack%0d", k), 64'(OACK), 64'b10);
            chk($sformatf("pkt_olck%0d", k), 64'(OLCK), (k < 3) ? 64'b10 : 64'b00);
        end
        chk("pkt_reqv_end", 64'(REQ_VALID), 64'd0);

        // interleaved packets: VC0 west, VC1 local
        a0h = mkf(2'b00, 29'h20, 2'd0, 2'd1);
        a1h = mkf(2'b00, 29'h30, 2'd1, 2'd1);
        a0t = mkf(2'b10, 29'h21, 2'd3, 2'd0);
        a1t = mkf(2'b10, 29'h31, 2'd0, 2'd3);
        push(1'b0, a0h); push(1'b1, a1h); push(1'b0, a0t); push(1'b1, a1t);
        cyc();
        chk("il_reqv",  64'(REQ_VALID), 64'b11);
        chk("il_port",  64'(REQ_PORT), 64'({5'b00001, 5'b00100}));
        chk("il_flit0", 64'(FLIT_OUT[34:0]), 64'(a0h));
        chk("il_flit1", 64'(FLIT_OUT[69:35]), 64'(a1h));
        GRANT = 2'b11; cyc(); GRANT = 2'b00;
        chk("il_oack_h", 64'(OACK), 64'b11);
        chk("il_olck_h", 64'(OLCK), 64'b11);
        chk("il_tail0",  64'(FLIT_OUT[34:0]), 64'(a0t));
        chk("il_tail1",  64'(FLIT_OUT[69:35]), 64'(a1t));
        chk("il_port_h", 64'(REQ_PORT), 64'({5'b00001, 5'b00100}));
        GRANT = 2'b11; cyc(); GRANT = 2'b00;
        chk("il_oack_t", 64'(OACK), 64'b11);
        chk("il_olck_t", 64'(OLCK), 64'b00);
        chk("il_reqv_t", 64'(REQ_VALID), 64'b00);
        chk("il_err",    64'(ERR), 64'd0);

        // fill VC0 to depth, overflow, then push-with-pop at full
        pk[0] = mkf(2'b00, 29'h40, 2'd1, 2'd2);
        pk[1] = mkf(2'b01, 29'h41, 2'd0, 2'd0);
        pk[2] = mkf(2'b01, 29'h42, 2'd0, 2'd0);
        pk[3] = mkf(2'b01, 29'h43, 2'd0, 2'd0);
        for (int k = 0; k < 4; k++) push(1'b0, pk[k]);
        chk("full_err_pre", 64'(ERR), 64'd0);
        push(1'b0, mkf(2'b10, 29'h99, 2'd0, 2'd0));
        chk("full_err",  64'(ERR), 64'd1);
        chk("full_reqv", 64'(REQ_VALID), 64'b01);
        chk("full_port", 64'(REQ_PORT[4:0]), 64'b01000);
        chk("full_head", 64'(FLIT_OUT[34:0]), 64'(pk[0]));
        f = mkf(2'b10, 29'h45, 2'd0, 2'd0);
        IVALID = 1'b1; IVCH = 1'b0; IDATA = f; GRANT = 2'b01;
        cyc();
        IVALID = 1'b0; GRANT = 2'b00;
        chk("full_pp_oack", 64'(OACK), 64'b01);
        chk("full_pp_olck", 64'(OLCK), 64'b01);
        pk[0] = pk[1]; pk[1] = pk[2]; pk[2] = pk[3]; pk[3] = f;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_flit%0d", k), 64'(FLIT_OUT[34:0]), 64'(pk[k]));
            GRANT = 2'b01; cyc(); GRANT = 2'b00;
        end
        chk("drain_reqv", 64'(REQ_VALID), 64'd0);
        chk("drain_olck", 64'(OLCK), 64'd0);

        // BODY into idle VC0 is discarded
        do_reset();
        chk("rst_err_clr", 64'(ERR), 64'd0);
        push(1'b0, mkf(2'b01, 29'h50, 2'd2, 2'd2));
        chk("body_reqv0", 64'(REQ_VALID), 64'd0);
        cyc();
        chk("body_oack",  64'(OACK), 64'b01);
        chk("body_err",   64'(ERR), 64'd1);
        chk("body_reqv1", 64'(REQ_VALID), 64'd0);
        chk("body_flit",  64'(FLIT_OUT[34:0]), 64'd0);
        cyc();
        chk("body_oack_off", 64'(OACK), 64'd0);

        // reset mid-packet on VC1 with 3 flits buffered
        do_reset();
        pk[0] = mkf(2'b00, 29'h60, 2'd3, 2'd3);
        pk[1] = mkf(2'b01, 29'h61, 2'd0, 2'd0);
        pk[2] = mkf(2'b01, 29'h62, 2'd0, 2'd0);
        pk[3] = mkf(2'b10, 29'h63, 2'd0, 2'd0);
        for (int k = 0; k < 4; k++) push(1'b1, pk[k]);
        GRANT = 2'b10; cyc(); GRANT = 2'b00;
        cyc();
        chk("mid_olck_pre", 64'(OLCK), 64'b10);
        chk("mid_reqv_pre", 64'(REQ_VALID), 64'b10);
        RST = 1'b1;
        #1;
        chk("mid_rst_olck", 64'(OLCK), 64'd0);
        chk("mid_rst_reqv", 64'(REQ_VALID), 64'd0);
        chk("mid_rst_port", 64'(REQ_PORT), 64'd0);
        chk("mid_rst_flit", 64'(FLIT_OUT), 64'd0);
        cyc(); cyc();
        chk("mid_rst_oack", 64'(OACK), 64'd0);
        RST = 1'b0;
        cyc();
        chk("mid_post_oack", 64'(OACK), 64'd0);
        f = mkf(2'b11, 29'h70, 2'd1, 2'd3);
        push(1'b1, f);
        cyc();
        chk("fresh_reqv", 64'(REQ_VALID), 64'b10);
        chk("fresh_port", 64'(REQ_PORT[9:5]), 64'b01000);
        chk("fresh_flit", 64'(FLIT_OUT[69:35]), 64'(f));
        GRANT = 2'b10; cyc(); GRANT = 2'b00;
        chk("fresh_oack", 64'(OACK), 64'b10);
        chk("fresh_olck", 64'(OLCK), 64'd0);

        // grant with no request raises ERR
        chk("gnr_err_pre", 64'(ERR), 64'd0);
        GRANT = 2'b01; cyc(); GRANT = 2'b00;
        chk("gnr_err", 64'(ERR), 64'd1);
        chk("gnr_oack", 64'(OACK), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
